descontador_n: RTL and testbench



---
 rtl/descontador_n_pkg.sv | 14 +
 rtl/descontador_presc.sv | 26 ++
 rtl/descontador_n.sv | 97 +++++++++
 tb/tb_descontador_n.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/descontador_n_pkg.sv
// Shared types and defaults for the contador library counters (contadorN, descontador_n).
package descontador_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } desc_state_t;

  localparam int unsigned CONTADOR_BITS_DEF    = 8;
  localparam int unsigned DESCONTADOR_BITS_DEF = 8;
  localparam int unsigned DESCONTADOR_PRESC_DEF = 4;

endpackage

// File: rtl/descontador_presc.sv
// Prescaler tick generator: pulses tick on every PRESC_DIV-th enabled falling edge of NEclk.
module descontador_presc #(
  parameter int unsigned PRESC_DIV = 4
) (
  input  logic NEclk,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic tick
);

  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [PW-1:0] presc;

  assign tick = Enable && (presc == PW'(PRESC_DIV - 1));

  always_ff @(negedge NEclk) begin
    if (Reset || Clear) begin
      presc <= '0;
    end else if (Enable) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/descontador_n.sv
// Loadable down-counter with registered terminal-count pulse and optional auto-reload.
// Define DESCONTADOR_PRESC_EN to step the count only every PRESC_DIV enabled edges.
module descontador_n
  import descontador_n_pkg::*;
#(
  parameter int unsigned BITS      = DESCONTADOR_BITS_DEF,
  parameter int unsigned PRESC_DIV = DESCONTADOR_PRESC_DEF
) (
  input  logic            NEclk,
  input  logic            Reset,
  input  logic            Enable,
  input  logic            Load,
  input  logic [BITS-1:0] LoadValue,
  input  logic            AutoReload,
  output logic [BITS-1:0] count,
  output logic            Zero,
  output logic            TC,
  output logic            Busy
);

  if (PRESC_DIV < 2) begin : g_div_check
    $error("descontador_n: PRESC_DIV must be >= 2");
  end

  desc_state_t     state, state_n;
  logic [BITS-1:0] reload, reload_n, count_n;
  logic            tc_n;
  logic            step;

`ifdef DESCONTADOR_PRESC_EN
  descontador_presc #(
    .PRESC_DIV (PRESC_DIV)
  ) u_presc (
    .NEclk  (NEclk),
    .Reset  (Reset),
    .Clear  (Load),
    .Enable (Enable),
    .tick   (step)
  );
`else
  assign step = Enable;
`endif

  always_ff @(negedge NEclk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      reload <= '0;
      TC     <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      TC     <= tc_n;
      Busy   <= (state_n == ST_RUN);
    end
  end

  // Load overrides any step, so a load on the terminal edge suppresses TC.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    tc_n     = 1'b0;
    if (Load) begin
      count_n  = LoadValue;
      reload_n = LoadValue;
      state_n  = (LoadValue != '0) ? ST_RUN : ST_DONE;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (step) begin
            if (count > BITS'(1)) begin
              count_n = count - 1'b1;
            end else begin
              tc_n = 1'b1;
              if (AutoReload) begin
                count_n = reload;
              end else begin
                count_n = '0;
                state_n = ST_DONE;
              end
            end
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Zero = (count == '0);
  end

endmodule

// File: tb/tb_descontador_n.sv
// Randomized and directed bench for descontador_n against a behavioural down-counter model.
module tb_descontador_n;

  localparam int unsigned BITS = 8;
  localparam int unsigned PDIV = 4;

  logic            NEclk = 1'b0;
  logic            Reset, Enable, Load, AutoReload;
  logic [BITS-1:0] LoadValue;
  logic [BITS-1:0] count;
  logic            Zero, TC, Busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // behavioural model state
  int m_count, m_reload, m_presc;
  bit m_running, m_tc;

  descontador_n #(
    .BITS      (BITS),
    .PRESC_DIV (PDIV)
  ) dut (
    .NEclk      (NEclk),
    .Reset      (Reset),
    .Enable     (Enable),
    .Load       (Load),
    .LoadValue  (LoadValue),
    .AutoReload (AutoReload),
    .count      (count),
    .Zero       (Zero),
    .TC         (TC),
    .Busy       (Busy)
  );

  always #5 NEclk = ~NEclk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(bit r, bit l, int lv, bit e, bit ar);
    bit adv;
    if (r) begin
      m_count = 0; m_reload = 0; m_presc = 0; m_running = 0; m_tc = 0;
    end else if (l) begin
      m_count = lv; m_reload = lv; m_presc = 0; m_running = (lv != 0); m_tc = 0;
    end else begin
      m_tc = 0;
`ifdef DESCONTADOR_PRESC_EN
      adv = 0;
      if (e) begin
        m_presc = m_presc + 1;
        if (m_presc == PDIV) begin
          adv = 1;
          m_presc = 0;
        end
      end
`else
      adv = e;
`endif
      if (m_running && adv) begin
        if (m_count == 1) begin
          m_tc = 1;
          if (ar) m_count = m_reload;
          else begin
            m_count = 0;
            m_running = 0;
          end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  endfunction

  // Inputs change and outputs are sampled on the rising edge, away from the active falling edge.
  task automatic cyc(bit r, bit l, int lv, bit e, bit ar);
    Reset = r; Load = l; LoadValue = BITS'(lv); Enable = e; AutoReload = ar;
    @(negedge NEclk);
    model_edge(r, l, lv, e, ar);
    @(posedge NEclk);
    check("count", int'(count), m_count);
    check("Zero", int'(Zero), int'(m_count == 0));
    check("TC", int'(TC), int'(m_tc));
    check("Busy", int'(Busy), int'(m_running));
  endtask

  initial begin
    bit r, l, e, ar;
    int lv;
    Reset = 1'b1; Load = 1'b0; LoadValue = '0; Enable = 1'b0; AutoReload = 1'b0;
    @(posedge NEclk);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    check("rst_count", int'(count), 0);
    check("rst_zero", int'(Zero), 1);
    cyc(0, 0, 0, 1, 0);
    check("idle_enable_ignored", int'(count), 0);

    // Load 5, count to zero and stop
    cyc(0, 1, 5, 1, 0);
    for (int i = 0; i < 7 * PDIV; i++) cyc(0, 0, 0, 1, 0);
    check("done_count", int'(count), 0);
    check("done_busy", int'(Busy), 0);

    // auto-reload of 3, then reload of 1 (TC every step)
    cyc(0, 1, 3, 1, 1);
    for (int i = 0; i < 9 * PDIV; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 1, 1, 1);
    for (int i = 0; i < 4 * PDIV; i++) cyc(0, 0, 0, 1, 1);

    // hold while Enable low
    cyc(0, 1, 6, 1, 0);
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0);

    // reload on the terminal edge suppresses TC
    cyc(0, 1, 4, 1, 0);
    while (count != 1 && checks < 4000) cyc(0, 0, 0, 1, 0);
    check("reached_one", int'(count), 1);
    cyc(0, 1, 7, 1, 0);
    check("load_at_one_count", int'(count), 7);
    check("load_at_one_tc", int'(TC), 0);
    cyc(0, 1, 0, 1, 0);
    check("load_zero_busy", int'(Busy), 0);
    cyc(0, 1, 5, 1, 0);
    cyc(1, 0, 0, 1, 0);
    check("mid_reset_count", int'(count), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      l  = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      e  = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      cyc(r, l, lv, e, ar);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
